// File: rtl/multicycle_mainfsm.sv
// Main control FSM for the multicycle ARM core: sequences fetch/decode/execute/
// memory/writeback and drives datapath selects plus unconditioned write requests.
module multicycle_mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD    = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR    = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_UNKNOWN  = STATE_W'(10);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  // Only I (bit 5) and L (bit 0) steer this FSM; the rest belong to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d   = S_FETCH;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    Illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
        state_d   = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
        state_d = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXECUTER: begin
        ALUOp   = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegW    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_UNKNOWN: begin
        Illegal = 1'b1;
        state_d = S_FETCH;
      end
      // Unreachable encodings recover to FETCH with all outputs idle.
      default: state_d = S_FETCH;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// Self-checking bench for multicycle_mainfsm: instruction-level model builds the
// expected per-cycle state/output sequence; DUT is compared every cycle.
module tb_multicycle_mainfsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;

  multicycle_mainfsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .Illegal(Illegal), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       irw;
    logic       adr;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] rs;
    logic       aluop;
    logic       npc;
    logic       regw;
    logic       memw;
    logic       br;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic       mr;
    int         st;
  } cyc_t;

  int   tests = 0;
  int   fails = 0;
  cyc_t plan[$];
  int   trace[$];
  int   n_irw, n_npc, n_regw, n_memw, n_br, n_ill;

  // Output table per state, straight from the state descriptions.
  function automatic exp_t exp_of(input int st, input logic mr);
    exp_t e;
    e = '0;
    e.st = 4'(st);
    case (st)
      0:  begin e.asa = 2'b01; e.asb = 2'b10; e.rs = 2'b10; e.irw = mr; e.npc = mr; end
      1:  begin e.asa = 2'b01; e.asb = 2'b10; e.rs = 2'b10; end
      2:  begin e.asb = 2'b01; end
      3:  begin e.adr = 1'b1; end
      4:  begin e.rs = 2'b01; e.regw = 1'b1; end
      5:  begin e.adr = 1'b1; e.memw = 1'b1; end
      6:  begin e.aluop = 1'b1; end
      7:  begin e.asb = 2'b01; e.aluop = 1'b1; end
      8:  begin e.regw = 1'b1; end
      9:  begin e.asa = 2'b10; e.asb = 2'b01; e.rs = 2'b10; e.br = 1'b1; end
      10: begin e.ill = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic exp_t dut_vec();
    return {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
            ALUOp, NextPC, RegW, MemW, Branch, Illegal};
  endfunction

  task automatic push(input logic [1:0] op, input logic [5:0] fn, input logic mr, input int st);
    cyc_t c;
    c.op = op; c.fn = fn; c.mr = mr; c.st = st;
    plan.push_back(c);
  endtask

  // Expand one instruction into cycles; opcode fields are garbage outside the
  // cycles that are allowed to look at them.
  task automatic plan_instr(input logic [1:0] op, input logic [5:0] fn,
                            input int fstall, input int mstall);
    logic [1:0] gop;
    logic [5:0] gfn;
    gop = ~op;
    gfn = ~fn;
    for (int i = 0; i < fstall; i++) push(gop, gfn, 1'b0, 0);
    push(gop, gfn, 1'b1, 0);
    push(op, fn, 1'b0, 1);
    if (op == 2'b00) begin
      push(gop, gfn, 1'b1, fn[5] ? 7 : 6);
      push(gop, gfn, 1'b0, 8);
    end else if (op == 2'b01) begin
      push(gop, fn, !fn[0], 2);
      for (int i = 0; i < mstall; i++) push(gop, gfn, 1'b0, fn[0] ? 3 : 5);
      push(gop, gfn, 1'b1, fn[0] ? 3 : 5);
      if (fn[0]) push(gop, gfn, 1'b0, 4);
    end else if (op == 2'b10) begin
      push(gop, gfn, 1'b1, 9);
    end else begin
      push(gop, gfn, 1'b0, 10);
    end
  endtask

  // Called at a falling edge; drives each cycle and compares away from posedge.
  task automatic run_plan(input string name);
    cyc_t c;
    exp_t e, a;
    trace.delete();
    n_irw = 0; n_npc = 0; n_regw = 0; n_memw = 0; n_br = 0; n_ill = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      Op = c.op; Funct = c.fn; MemReady = c.mr;
      #1;
      e = exp_of(c.st, c.mr);
      a = dut_vec();
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s cyc%0d: got %05h expected %05h", name, trace.size(), a, e);
      end
      trace.push_back(int'(State));
      n_irw += int'(IRWrite); n_npc += int'(NextPC); n_regw += int'(RegW);
      n_memw += int'(MemW);   n_br += int'(Branch);  n_ill += int'(Illegal);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_trace(input string name, input int expt[$]);
    chk({name, "_len"}, trace.size(), expt.size());
    for (int i = 0; i < expt.size() && i < trace.size(); i++)
      chk($sformatf("%s_st%0d", name, i), trace[i], expt[i]);
  endtask

  task automatic chk_vec(input string name, input exp_t e);
    exp_t a;
    a = dut_vec();
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %05h expected %05h", name, a, e);
    end
  endtask

  initial begin
    reset = 1'b0; MemReady = 1'b1; Op = 2'b00; Funct = 6'd0;
    #3 chk_vec("reset_mr1", exp_of(0, 1'b1));
    MemReady = 1'b0;
    #1 chk_vec("reset_mr0", exp_of(0, 1'b0));
    MemReady = 1'b1;
    @(negedge clk);
    chk_vec("reset_held_edge", exp_of(0, 1'b1));
    reset = 1'b1;

    plan_instr(2'b00, 6'b001000, 0, 0);
    run_plan("add_reg");
    chk_trace("add_reg_trace", '{0, 1, 6, 8});
    chk("add_reg_regw", n_regw, 1);

    plan_instr(2'b00, 6'b101001, 0, 0);
    run_plan("add_imm");
    chk_trace("add_imm_trace", '{0, 1, 7, 8});

    plan_instr(2'b01, 6'b011001, 0, 2);
    run_plan("ldr_stall");
    chk_trace("ldr_trace", '{0, 1, 2, 3, 3, 3, 4});
    chk("ldr_regw", n_regw, 1);

    plan_instr(2'b01, 6'b011000, 3, 0);
    run_plan("str_fstall");
    chk_trace("str_trace", '{0, 0, 0, 0, 1, 2, 5});
    chk("str_irwrite", n_irw, 1);
    chk("str_memw", n_memw, 1);

    plan_instr(2'b01, 6'b011000, 0, 2);
    run_plan("str_mstall");
    chk("str_stall_memw", n_memw, 3);

    plan_instr(2'b10, 6'b100001, 0, 0);
    run_plan("branch");
    chk_trace("branch_trace", '{0, 1, 9});
    chk("branch_br", n_br, 1);
    chk("branch_npc", n_npc, 1);

    plan_instr(2'b11, 6'b000000, 0, 0);
    run_plan("undef");
    chk_trace("undef_trace", '{0, 1, 10});
    chk("undef_ill", n_ill, 1);
    chk("undef_writes", n_regw + n_memw + n_br, 0);

    // Abort a store stalled in MEMWR with an asynchronous reset.
    plan_instr(2'b01, 6'b000000, 0, 1);
    void'(plan.pop_back());
    run_plan("str_pre_abort");
    chk("abort_in_memwr", int'(State), 5);
    #2 reset = 1'b0; MemReady = 1'b1;
    #1 chk_vec("async_reset", exp_of(0, 1'b1));
    chk("async_memw", int'(MemW), 0);
    @(negedge clk);
    chk_vec("reset_hold", exp_of(0, 1'b1));
    reset = 1'b1;

    plan_instr(2'b00, 6'b000100, 0, 0);
    run_plan("add_after_reset");
    chk_trace("restart_trace", '{0, 1, 6, 8});

    plan_instr(2'b10, 6'b000000, 1, 0);
    run_plan("branch_tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_mainfsm.md
# multicycle_mainfsm

Main control state machine for the multicycle ARM core. It sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives the datapath multiplexer selects and produces the unconditioned `RegW`, `MemW` and `Branch` requests. These requests feed the downstream conditional-logic stage, which gates them with the condition-check result; `NextPC` bypasses that gating. It sits between the instruction decoder fields and the conditional-logic stage.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low (asserted when 0); forces state to FETCH immediately.
- `Op` in 2: instr[27:26]; 00 data-processing, 01 memory, 10 branch, 11 undefined.
- `Funct` in 6: instr[25:20]; Funct[5] = I (immediate), Funct[0] = L (load).
- `MemReady` in 1: memory handshake; 1 = access completes this cycle.
- `IRWrite` out 1: instruction register load enable.
- `AdrSrc` out 1: 0 = PC, 1 = ALU result as memory address.
- `ALUSrcA` out 2: 00 = register A, 01 = PC, 10 = ALUOut.
- `ALUSrcB` out 2: 00 = register B, 01 = extended immediate, 10 = constant 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = read data, 10 = ALU result.
- `ALUOp` out 1: 1 = ALU decoder uses Funct, 0 = forced add.
- `NextPC` out 1: unconditional PC write.
- `RegW` out 1: register-write request (pre-condition).
- `MemW` out 1: memory-write request (pre-condition).
- `Branch` out 1: branch request (pre-condition).
- `Illegal` out 1: one-cycle pulse on undefined opcode.
- `State` out 4: current state encoding, for debug.

## Operation
- Moore machine: outputs are a function of state, except where qualified by `MemReady`. Any output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. Codes 11–15 are unreachable and must return to FETCH on the next edge.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - IRWrite = NextPC = MemReady.
  - Next state: DECODE if MemReady, else hold FETCH.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - Next state by opcode: Op=01 → MEMADR; Op=00 and Funct[5]=0 → EXECUTER; Op=00 and Funct[5]=1 → EXECUTEI; Op=10 → BRANCH; Op=11 → UNKNOWN.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0. Next state: Funct[0]=1 → MEMRD, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state: MEMWB if MemReady, else hold MEMRD.
- MEMWB: ResultSrc=01, RegW=1. Next state: FETCH.
- MEMWR:
  - Outputs: AdrSrc=1, ResultSrc=00, MemW=1.
  - MemW stays high for every stalled cycle.
  - Next state: FETCH if MemReady, else hold MEMWR.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1. Next state: ALUWB.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegW=1. Next state: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1. Next state: FETCH.
- UNKNOWN: Illegal=1. Next state: FETCH.
- `Op`, `Funct` and `MemReady` are sampled only in the states that use them; changes in other states have no effect.

## Timing
- While reset=0: State=0 (FETCH) and outputs hold FETCH values (IRWrite/NextPC follow MemReady). Reset deassertion is assumed synchronous to clk by the reset synchronizer.
- Reset asserted mid-instruction aborts it. Any RegW/MemW/Branch in progress drops asynchronously with the state.
- Instruction latency with MemReady held at 1:
  - LDR: 5 cycles (F, D, MA, MR, MWB).
  - STR: 4 cycles (F, D, MA, MW).
  - Data-processing: 4 cycles (F, D, EX, WB).
  - Branch: 3 cycles (F, D, B).
  - Undefined: 3 cycles (F, D, U).
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs stay stable throughout the stall.
- MemReady=1 on the same edge that the state is entered has no effect until the state is current.

## Test plan
- ADD register: release reset with MemReady=1, Op=00, Funct=6'b001000 → State 0,1,6,8,0. RegW=1 only in state 8. ALUOp=1 only in state 6.
- LDR with 2-cycle read stall: Op=01, Funct[0]=1, MemReady low for the first 2 MEMRD cycles → State 0,1,2,3,3,3,4,0. RegW=1 for one cycle with ResultSrc=01.
- STR with fetch stall: MemReady=0 for 3 FETCH cycles, then Op=01, Funct[0]=0 → IRWrite=0 for 3 cycles, then 1 for 1 cycle. MemW=1 for exactly 1 cycle in state 5 with AdrSrc=1.
- Branch: Op=10 → State 0,1,9,0. In state 9: Branch=1, ALUSrcA=10, ALUSrcB=01. NextPC=1 only in FETCH.
- Undefined: Op=11 → State 0,1,10,0. Illegal pulses once. RegW, MemW and Branch stay 0.
- Async reset: drive reset=0 mid-cycle while in MEMWR → State=0 and MemW=0 before the next clk edge. After release, the fetch sequence restarts.
